cmd_timing_gate: RTL and testbench

//  Consumer of the per-bank timing state produced by the tP_counter instances. Holds one pending DRAM

---
 rtl/cmd_timing_gate_pkg.sv | 64 ++++++
 rtl/cmd_timing_gate_counter.sv | 43 ++++
 rtl/cmd_timing_gate.sv | 209 ++++++++++++++++++++
 tb/tb_cmd_timing_gate.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_timing_gate_pkg.sv
// ----------------------------------------------------------------------------
// cmd_timing_gate_pkg: command, bank-state and gate FSM types plus default timings.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef BA_BITS
`define BA_BITS 3
`endif
`ifndef CYCLE_TRAS
`define CYCLE_TRAS 10
`endif
`ifndef CYCLE_TRRD
`define CYCLE_TRRD 4
`endif
`ifndef CYCLE_TFAW
`define CYCLE_TFAW 16
`endif

package cmd_timing_gate_pkg;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_ACT   = 3'd1,
    CMD_READ  = 3'd2,
    CMD_WRITE = 3'd3,
    CMD_PRE   = 3'd4,
    CMD_REF   = 3'd5
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE                 = 3'd0,
    ACTIVE_TO_READ_WRITE = 3'd1,
    READ_TO_PRECHARGE    = 3'd2,
    WRITE_TO_PRECHARGE   = 3'd3,
    PRECHARGE_TO_ACTIVE  = 3'd4,
    PRECHARGE_TO_REFRESH = 3'd5,
    REFRESH_TO_IDLE      = 3'd6
  } recode_state_t;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } gate_state_t;

  localparam int FAW_SLOTS = 4;

  // Counter holds cycles-1 at most; a window of 0 or 1 cycles never loads a nonzero value.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  function automatic int cnt_load(input int cycles);
    return (cycles > 1) ? cycles - 1 : 0;
  endfunction

  function automatic logic is_open_row(input recode_state_t rc);
    return (rc == ACTIVE_TO_READ_WRITE) || (rc == READ_TO_PRECHARGE) ||
           (rc == WRITE_TO_PRECHARGE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_timing_gate_counter.sv
// ----------------------------------------------------------------------------
// sat_down_counter: loadable down-counter that sticks at zero; load beats decrement.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (value_q != '0) begin
      value_d = value_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

`default_nettype wire

// File: rtl/cmd_timing_gate.sv
// ----------------------------------------------------------------------------
// cmd_timing_gate: holds one DRAM command and releases it once bank timing allows.
// Define TFAW_CHECK_EN to add the four-activate window. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cmd_timing_gate
  import cmd_timing_gate_pkg::*;
#(
  parameter int NUM_BANKS  = 8,
  parameter int CYCLE_TRAS = `CYCLE_TRAS,
  parameter int CYCLE_TRRD = `CYCLE_TRRD,
  parameter int CYCLE_TFAW = `CYCLE_TFAW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  cmd_t                           req_cmd,
  input  logic [`BA_BITS-1:0]            req_bank,
  input  logic [NUM_BANKS-1:0][4:0]      tP_ba_counter,
  input  recode_state_t [NUM_BANKS-1:0]  recode,
  output logic                           issue_valid,
  output cmd_t                           issue_cmd,
  output logic [`BA_BITS-1:0]            issue_bank,
  output logic                           illegal_err,
  output logic [7:0]                     stall_cnt
);

  localparam int BA_BITS   = `BA_BITS;
  localparam int TRAS_W    = cnt_width(CYCLE_TRAS);
  localparam int TRRD_W    = cnt_width(CYCLE_TRRD);
  localparam int TRAS_LOAD = cnt_load(CYCLE_TRAS);
  localparam int TRRD_LOAD = cnt_load(CYCLE_TRRD);

  gate_state_t        state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [BA_BITS-1:0] bank_q, bank_d;
  logic               issue_valid_q, issue_valid_d;
  cmd_t               issue_cmd_q, issue_cmd_d;
  logic [BA_BITS-1:0] issue_bank_q, issue_bank_d;
  logic               illegal_err_q, illegal_err_d;
  logic [7:0]         stall_cnt_q, stall_cnt_d;

  logic [4:0]         tp;
  recode_state_t      rc;
  logic               any_open, all_tp_zero;
  logic               legal, timing_ok;
  logic               in_hold, fire_ok, fire_ill, accept, act_fire;
  logic               trrd_zero, faw_free;
  logic [NUM_BANKS-1:0]             tras_zero, tras_load;
  logic [NUM_BANKS-1:0][TRAS_W-1:0] tras_val;
  logic [TRRD_W-1:0]                trrd_val;

  assign tp = tP_ba_counter[bank_q];
  assign rc = recode[bank_q];

  always_comb begin
    any_open    = 1'b0;
    all_tp_zero = 1'b1;
    tras_load   = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (is_open_row(recode[i])) any_open = 1'b1;
      if (tP_ba_counter[i] != 5'd0) all_tp_zero = 1'b0;
      tras_load[i] = act_fire && (bank_q == BA_BITS'(i));
    end
  end

  always_comb begin
    legal     = 1'b0;
    timing_ok = 1'b0;
    case (cmd_q)
      CMD_ACT: begin
        legal     = (rc == IDLE) || (rc == PRECHARGE_TO_ACTIVE) || (rc == PRECHARGE_TO_REFRESH);
        timing_ok = (tp == 5'd0) && trrd_zero && faw_free;
      end
      CMD_READ, CMD_WRITE: begin
        legal     = is_open_row(rc);
        timing_ok = (rc != ACTIVE_TO_READ_WRITE) || (tp == 5'd0);
      end
      CMD_PRE: begin
        legal     = is_open_row(rc);
        timing_ok = (tp == 5'd0) && tras_zero[bank_q];
      end
      CMD_REF: begin
        legal     = !any_open;
        timing_ok = all_tp_zero;
      end
      default: ;
    endcase
  end

  assign in_hold   = (state_q == S_HOLD);
  assign fire_ok   = in_hold && legal && timing_ok;
  assign fire_ill  = in_hold && !legal;
  assign req_ready = (state_q == S_EMPTY) || fire_ok || fire_ill;
  assign accept    = req_valid && req_ready;
  assign act_fire  = fire_ok && (cmd_q == CMD_ACT);

  // A release and a new capture can share one edge; the FSM then stays in S_HOLD.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    bank_d        = bank_q;
    issue_valid_d = fire_ok;
    issue_cmd_d   = fire_ok ? cmd_q : issue_cmd_q;
    issue_bank_d  = fire_ok ? bank_q : issue_bank_q;
    illegal_err_d = fire_ill;
    stall_cnt_d   = stall_cnt_q;
    if (in_hold && !fire_ok && !fire_ill && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
    if (accept) begin
      state_d     = S_HOLD;
      cmd_d       = req_cmd;
      bank_d      = (req_cmd == CMD_REF) ? '0 : req_bank;
      stall_cnt_d = 8'd0;
    end else if (fire_ok || fire_ill) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_EMPTY;
      cmd_q         <= CMD_NOP;
      bank_q        <= '0;
      issue_valid_q <= 1'b0;
      issue_cmd_q   <= CMD_NOP;
      issue_bank_q  <= '0;
      illegal_err_q <= 1'b0;
      stall_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      bank_q        <= bank_d;
      issue_valid_q <= issue_valid_d;
      issue_cmd_q   <= issue_cmd_d;
      issue_bank_q  <= issue_bank_d;
      illegal_err_q <= illegal_err_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_cmd   = issue_cmd_q;
  assign issue_bank  = issue_bank_q;
  assign illegal_err = illegal_err_q;
  assign stall_cnt   = stall_cnt_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_tras
    sat_down_counter #(.W(TRAS_W)) u_tras (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tras_load[b]),
      .load_val (TRAS_W'(TRAS_LOAD)),
      .value    (tras_val[b]),
      .zero     (tras_zero[b])
    );
  end

  sat_down_counter #(.W(TRRD_W)) u_trrd (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (act_fire),
    .load_val (TRRD_W'(TRRD_LOAD)),
    .value    (trrd_val),
    .zero     (trrd_zero)
  );

`ifdef TFAW_CHECK_EN
  localparam int FAW_W    = cnt_width(CYCLE_TFAW);
  localparam int FAW_LOAD = cnt_load(CYCLE_TFAW);

  logic [FAW_SLOTS-1:0]            faw_zero, faw_load;
  logic [FAW_SLOTS-1:0][FAW_W-1:0] faw_val;
  logic                            faw_found;

  // Each ACT claims the lowest-index expired slot.
  always_comb begin
    faw_load  = '0;
    faw_found = 1'b0;
    for (int s = 0; s < FAW_SLOTS; s++) begin
      if (act_fire && faw_zero[s] && !faw_found) begin
        faw_load[s] = 1'b1;
        faw_found   = 1'b1;
      end
    end
  end

  assign faw_free = |faw_zero;

  for (genvar s = 0; s < FAW_SLOTS; s++) begin : g_faw
    sat_down_counter #(.W(FAW_W)) u_faw (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (faw_load[s]),
      .load_val (FAW_W'(FAW_LOAD)),
      .value    (faw_val[s]),
      .zero     (faw_zero[s])
    );
  end
`else
  assign faw_free = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmd_timing_gate.sv
// ----------------------------------------------------------------------------
// tb_cmd_timing_gate: directed vector table plus multi-cycle timing sequences.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cmd_timing_gate;
  import cmd_timing_gate_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                      req_valid, req_ready, issue_valid, illegal_err;
  cmd_t                      req_cmd, issue_cmd;
  logic [`BA_BITS-1:0]       req_bank, issue_bank;
  logic [7:0]                stall_cnt;
  logic [7:0][4:0]           tp_arr;
  recode_state_t [7:0]       rc_arr;

  logic                      req_valid_f, req_ready_f, issue_valid_f, illegal_err_f;
  cmd_t                      req_cmd_f, issue_cmd_f;
  logic [`BA_BITS-1:0]       req_bank_f, issue_bank_f;
  logic [7:0]                stall_cnt_f;

  cmd_timing_gate #(.NUM_BANKS(8), .CYCLE_TRAS(10), .CYCLE_TRRD(4), .CYCLE_TFAW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_bank(req_bank), .tP_ba_counter(tp_arr), .recode(rc_arr),
    .issue_valid(issue_valid), .issue_cmd(issue_cmd), .issue_bank(issue_bank),
    .illegal_err(illegal_err), .stall_cnt(stall_cnt)
  );

  cmd_timing_gate #(.NUM_BANKS(8), .CYCLE_TRAS(10), .CYCLE_TRRD(1), .CYCLE_TFAW(16)) dut_f (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_f), .req_ready(req_ready_f),
    .req_cmd(req_cmd_f), .req_bank(req_bank_f), .tP_ba_counter(tp_arr), .recode(rc_arr),
    .issue_valid(issue_valid_f), .issue_cmd(issue_cmd_f), .issue_bank(issue_bank_f),
    .illegal_err(illegal_err_f), .stall_cnt(stall_cnt_f)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_banks();
    for (int i = 0; i < 8; i++) begin
      rc_arr[i] = IDLE;
      tp_arr[i] = 5'd0;
    end
  endtask

  // Cycles from the current point until issue_valid is seen, bounded.
  task automatic wait_issue(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!issue_valid && n < 40);
  endtask

  typedef struct packed {
    cmd_t          cmd;
    logic [2:0]    bank;
    recode_state_t rc;
    logic [4:0]    tp;
    logic          rdy;
    logic          iss;
    logic          ill;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int n;
  int cyc, idx, n_iss, exp_gap;
  int iss_cyc [5];
  logic accepted;

  initial begin
    vecs[0]  = '{CMD_ACT,   3'd1, IDLE,                 5'd0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{CMD_ACT,   3'd1, PRECHARGE_TO_ACTIVE,  5'd5, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{CMD_ACT,   3'd2, ACTIVE_TO_READ_WRITE, 5'd0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{CMD_READ,  3'd3, ACTIVE_TO_READ_WRITE, 5'd2, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{CMD_READ,  3'd3, READ_TO_PRECHARGE,    5'd7, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{CMD_WRITE, 3'd4, WRITE_TO_PRECHARGE,   5'd0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{CMD_WRITE, 3'd4, IDLE,                 5'd0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{CMD_PRE,   3'd6, READ_TO_PRECHARGE,    5'd0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{CMD_PRE,   3'd6, READ_TO_PRECHARGE,    5'd3, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{CMD_PRE,   3'd7, PRECHARGE_TO_REFRESH, 5'd0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{CMD_REF,   3'd0, IDLE,                 5'd0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{CMD_REF,   3'd5, ACTIVE_TO_READ_WRITE, 5'd0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{CMD_REF,   3'd5, PRECHARGE_TO_REFRESH, 5'd4, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{CMD_ACT,   3'd0, PRECHARGE_TO_REFRESH, 5'd0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{CMD_READ,  3'd5, PRECHARGE_TO_ACTIVE,  5'd0, 1'b1, 1'b0, 1'b1};

    clear_banks();
    req_valid = 1'b1; req_cmd = CMD_ACT; req_bank = '0;
    req_valid_f = 1'b0; req_cmd_f = CMD_ACT; req_bank_f = '0;

    // Reset held with a request pending: nothing captured, nothing issued.
    repeat (3) tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_cmd", issue_cmd, CMD_NOP);
    chk("rst_issue_bank", issue_bank, 0);
    chk("rst_illegal", illegal_err, 0);
    chk("rst_stall", stall_cnt, 0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    n = 0;
    repeat (4) begin
      tick();
      if (issue_valid) n++;
    end
    chk("rst_no_capture", n, 0);

    for (int v = 0; v < NV; v++) begin
      clear_banks();
      rc_arr[vecs[v].bank] = vecs[v].rc;
      tp_arr[vecs[v].bank] = vecs[v].tp;
      req_valid = 1'b1; req_cmd = vecs[v].cmd; req_bank = vecs[v].bank;
      tick();
      req_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_ready", v), req_ready, vecs[v].rdy);
      tick();
      chk($sformatf("vec%0d_issue", v), issue_valid, vecs[v].iss);
      chk($sformatf("vec%0d_illegal", v), illegal_err, vecs[v].ill);
      if (vecs[v].iss) begin
        chk($sformatf("vec%0d_cmd", v), issue_cmd, vecs[v].cmd);
        if (vecs[v].cmd != CMD_REF) chk($sformatf("vec%0d_bank", v), issue_bank, vecs[v].bank);
      end
      tp_arr = '0;
      repeat (12) tick();
    end
    clear_banks();

    // ACT b2 then READ b2 waiting on a counting-down tp.
    req_valid = 1'b1; req_cmd = CMD_ACT; req_bank = 3'd2;
    tick();
    req_cmd = CMD_READ;
    tick();
    chk("rd_act_issue", issue_valid, 1);
    chk("rd_act_cmd", issue_cmd, CMD_ACT);
    chk("rd_stall_clear", stall_cnt, 0);
    req_valid = 1'b0;
    rc_arr[2] = ACTIVE_TO_READ_WRITE;
    tp_arr[2] = 5'd3;
    #1;
    chk("rd_wait_ready", req_ready, 0);
    n = 0;
    for (int t = 2; t >= 0; t--) begin
      tick();
      if (issue_valid) n++;
      tp_arr[2] = 5'(t);
    end
    chk("rd_no_early_issue", n, 0);
    chk("rd_stall_3", stall_cnt, 3);
    tick();
    chk("rd_issue", issue_valid, 1);
    chk("rd_cmd", issue_cmd, CMD_READ);
    chk("rd_bank", issue_bank, 2);
    clear_banks();
    repeat (12) tick();

    // tRRD: ACT b0 then ACT b1 back to back.
    req_valid = 1'b1; req_cmd = CMD_ACT; req_bank = 3'd0;
    tick();
    req_bank = 3'd1;
    tick();
    chk("trrd_first_issue", issue_valid, 1);
    req_valid = 1'b0;
    wait_issue(n);
    chk("trrd_gap", n, 4);
    chk("trrd_bank", issue_bank, 1);
    repeat (12) tick();

    // tRAS: PRE b3 captured at the ACT b3 release edge.
    req_valid = 1'b1; req_cmd = CMD_ACT; req_bank = 3'd3;
    tick();
    req_cmd = CMD_PRE;
    tick();
    chk("tras_act_issue", issue_valid, 1);
    req_valid = 1'b0;
    rc_arr[3] = ACTIVE_TO_READ_WRITE;
    wait_issue(n);
    chk("tras_gap", n, 10);
    chk("tras_cmd", issue_cmd, CMD_PRE);
    clear_banks();
    repeat (12) tick();

    // Reset while an entry is held.
    rc_arr[5] = ACTIVE_TO_READ_WRITE; tp_arr[5] = 5'd3;
    req_valid = 1'b1; req_cmd = CMD_READ; req_bank = 3'd5;
    tick();
    req_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", req_ready, 1);
    chk("midrst_stall", stall_cnt, 0);
    tick();
    rst_n = 1'b1;
    tp_arr[5] = 5'd0;
    n = 0;
    repeat (6) begin
      tick();
      if (issue_valid) n++;
    end
    chk("midrst_no_issue", n, 0);
    clear_banks();

    // Five back-to-back ACTs on the tRRD=1 instance.
    `ifdef TFAW_CHECK_EN
      exp_gap = 16;
    `else
      exp_gap = 4;
    `endif
    cyc = 0; idx = 0; n_iss = 0;
    req_valid_f = 1'b1; req_cmd_f = CMD_ACT; req_bank_f = 3'd0;
    while (n_iss < 5 && cyc < 80) begin
      #1;
      accepted = req_valid_f && req_ready_f;
      tick();
      cyc++;
      if (issue_valid_f) begin
        chk($sformatf("faw_bank%0d", n_iss), issue_bank_f, n_iss);
        iss_cyc[n_iss] = cyc;
        n_iss++;
      end
      if (accepted) begin
        idx++;
        if (idx == 5) req_valid_f = 1'b0;
        else req_bank_f = 3'(idx);
      end
    end
    chk("faw_count", n_iss, 5);
    if (n_iss == 5) begin
      chk("faw_gap2", iss_cyc[1] - iss_cyc[0], 1);
      chk("faw_gap5", iss_cyc[4] - iss_cyc[0], exp_gap);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
